// File: rtl/shift_sub_divider32.sv
// shift_sub_divider32: restoring shift-and-subtract divider that produces one quotient bit per clock.
// Defining SIGNED_DIV_EN selects two's-complement operands; this uses magnitude division plus a sign fix-up.
module shift_sub_divider32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d, dvd_q, dvd_d, dsr_q, dsr_d, quo_q, quo_d, rem_q, rem_d;
  logic busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH:0] r_sh;
  logic [WIDTH-1:0] r_new, q_next, dvd_in, dsr_in, fix_q, fix_r;
  logic accept, run, last, q_bit;
`ifdef SIGNED_DIV_EN
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;
`endif
  always_comb begin
    accept = start && state_q != RUN;
    run    = state_q == RUN;
    last   = run && cnt_q == CNT_W'(WIDTH-1);
    r_sh   = {r_q, dvd_q[WIDTH-1]};
    q_bit  = r_sh >= {1'b0, dsr_q};
    r_new  = q_bit ? WIDTH'(r_sh - {1'b0, dsr_q}) : r_sh[WIDTH-1:0];
    q_next = {dvd_q[WIDTH-2:0], q_bit};
`ifdef SIGNED_DIV_EN
    dvd_in  = dividend[WIDTH-1] ? -dividend : dividend;
    dsr_in  = divisor[WIDTH-1] ? -divisor : divisor;
    neg_q_d = accept ? dividend[WIDTH-1] ^ divisor[WIDTH-1] : neg_q_q;
    neg_r_d = accept ? dividend[WIDTH-1] : neg_r_q;
    // A zero divisor keeps the all-ones quotient; the remainder sign restores the original dividend.
    fix_q   = (neg_q_q && dsr_q != '0) ? -q_next : q_next;
    fix_r   = neg_r_q ? -r_new : r_new;
`else
    dvd_in = dividend;
    dsr_in = divisor;
    fix_q  = q_next;
    fix_r  = r_new;
`endif
    r_d     = accept ? '0 : run ? r_new : r_q;
    dvd_d   = accept ? dvd_in : run ? q_next : dvd_q;
    dsr_d   = accept ? dsr_in : dsr_q;
    cnt_d   = accept ? '0 : run ? cnt_q + CNT_W'(1) : cnt_q;
    state_d = accept ? RUN : last ? DONE : state_q == DONE ? IDLE : state_q;
    busy_d  = state_d == RUN;
    done_d  = state_d == DONE;
    quo_d   = last ? fix_q : quo_q;
    rem_d   = last ? fix_r : rem_q;
    dbz_d   = last ? dsr_q == '0 : dbz_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule
